sram_like_arbiter: RTL and testbench

//  Parametrised N-channel sram-like arbiter. Merges NUM_CH sram-like master ports onto one sram-like

---
 rtl/sram_like_arbiter.sv | 139 +++++++++++++
 tb/tb_sram_like_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_arbiter.sv
// N-channel sram-like arbiter: merges master ports onto one slave port and routes
// in-order responses back through an ID FIFO of accepted requests.
module sram_like_arbiter #(
  parameter int NUM_CH          = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int RR_MODE         = 0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CH-1:0]                  m_req,
  input  logic [NUM_CH-1:0]                  m_wr,
  input  logic [2*NUM_CH-1:0]                m_size,
  input  logic [ADDR_W*NUM_CH-1:0]           m_addr,
  input  logic [DATA_W*NUM_CH-1:0]           m_wdata,
  output logic [NUM_CH-1:0]                  m_addr_ok,
  output logic [NUM_CH-1:0]                  m_data_ok,
  output logic [DATA_W-1:0]                  m_rdata,
  output logic                               s_req,
  output logic                               s_wr,
  output logic [1:0]                         s_size,
  output logic [ADDR_W-1:0]                  s_addr,
  output logic [DATA_W-1:0]                  s_wdata,
  input  logic                               s_addr_ok,
  input  logic                               s_data_ok,
  input  logic [DATA_W-1:0]                  s_rdata,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               proto_err
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  logic [CH_W-1:0]  r_fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_lock;
  logic [CH_W-1:0]  r_lock_ch;
  logic [CH_W-1:0]  r_rr_ptr;
  logic             r_proto_err;

  logic [CH_W-1:0]  w_grant;
  logic [CH_W-1:0]  w_lowest;
  logic [CH_W-1:0]  w_rr_hi;
  logic             w_rr_hi_found;
  logic             w_lock_hold;
  logic             w_lock_drop;
  logic             w_full;
  logic             w_empty;
  logic             w_s_req;
  logic             w_push;
  logic             w_pop;
  logic [CH_W-1:0]  w_head;
  logic [CH_W-1:0]  w_rr_next;

  assign w_full      = (r_count == CNT_W'(MAX_OUTSTANDING));
  assign w_empty     = (r_count == '0);
  assign w_lock_hold = r_lock & m_req[r_lock_ch];
  assign w_lock_drop = r_lock & ~m_req[r_lock_ch];
  // Full is judged on the registered count so a same-cycle pop cannot reopen the port.
  assign w_s_req     = (|m_req) & ~w_full;
  assign w_push      = w_s_req & s_addr_ok;
  assign w_pop       = s_data_ok & ~w_empty;
  assign w_head      = r_fifo[r_rptr];
  assign w_rr_next   = (w_grant == CH_W'(NUM_CH - 1)) ? '0 : w_grant + 1'b1;

  always_comb begin
    w_lowest      = '0;
    w_rr_hi       = '0;
    w_rr_hi_found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m_req[i]) begin
        w_lowest = CH_W'(i);
        if (i >= int'(r_rr_ptr)) begin
          w_rr_hi       = CH_W'(i);
          w_rr_hi_found = 1'b1;
        end
      end
    end
  end

  // A held lock overrides priority; a withdrawn lock falls through to fresh arbitration.
  always_comb begin
    w_grant = w_lowest;
    if (w_lock_hold) begin
      w_grant = r_lock_ch;
    end else if (RR_MODE != 0 && w_rr_hi_found) begin
      w_grant = w_rr_hi;
    end
  end

  always_comb begin
    s_req     = w_s_req;
    s_wr      = w_s_req & m_wr[w_grant];
    s_size    = w_s_req ? m_size[int'(w_grant)*2 +: 2] : 2'b00;
    s_addr    = w_s_req ? m_addr[int'(w_grant)*ADDR_W +: ADDR_W] : '0;
    s_wdata   = w_s_req ? m_wdata[int'(w_grant)*DATA_W +: DATA_W] : '0;
    m_addr_ok = '0;
    m_data_ok = '0;
    m_rdata   = w_pop ? s_rdata : '0;
    if (w_push) m_addr_ok[w_grant] = 1'b1;
    if (w_pop)  m_data_ok[w_head]  = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) r_fifo[i] <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_lock      <= 1'b0;
      r_lock_ch   <= '0;
      r_rr_ptr    <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= w_grant;
        r_wptr         <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_lock    <= w_s_req & ~s_addr_ok;
      r_lock_ch <= w_grant;
      if (RR_MODE != 0 && w_push) r_rr_ptr <= w_rr_next;
      if (w_lock_drop || (s_data_ok && w_empty)) r_proto_err <= 1'b1;
    end
  end

  assign outstanding = r_count;
  assign proto_err   = r_proto_err;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench: one fixed-priority and one round-robin instance share all inputs;
// expected response channels are queued at accept time and popped on data_ok.
module tb_sram_like_arbiter;

  localparam logic [31:0] A0 = 32'h1FC0_0000;
  localparam logic [31:0] A1 = 32'h8000_1000;
  localparam logic [31:0] W0 = 32'h1111_2222;
  localparam logic [31:0] W1 = 32'h3333_4444;

  logic        clk;
  logic        reset;
  logic [1:0]  m_req;
  logic [1:0]  m_wr;
  logic [3:0]  m_size;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic        s_addr_ok;
  logic        s_data_ok;
  logic [31:0] s_rdata;

  logic [1:0]  f_m_addr_ok, f_m_data_ok, r_m_addr_ok, r_m_data_ok;
  logic [31:0] f_m_rdata, r_m_rdata;
  logic        f_s_req, f_s_wr, r_s_req, r_s_wr;
  logic [1:0]  f_s_size, r_s_size;
  logic [31:0] f_s_addr, f_s_wdata, r_s_addr, r_s_wdata;
  logic [2:0]  f_out, r_out;
  logic        f_perr, r_perr;

  logic [1:0]  exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  sram_like_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(4), .RR_MODE(0)) u_fix (
    .clk(clk), .reset(reset), .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_addr_ok(f_m_addr_ok), .m_data_ok(f_m_data_ok), .m_rdata(f_m_rdata),
    .s_req(f_s_req), .s_wr(f_s_wr), .s_size(f_s_size), .s_addr(f_s_addr), .s_wdata(f_s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .outstanding(f_out), .proto_err(f_perr)
  );

  sram_like_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(4), .RR_MODE(1)) u_rr (
    .clk(clk), .reset(reset), .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_addr_ok(r_m_addr_ok), .m_data_ok(r_m_data_ok), .m_rdata(r_m_rdata),
    .s_req(r_s_req), .s_wr(r_s_wr), .s_size(r_s_size), .s_addr(r_s_addr), .s_wdata(r_s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .outstanding(r_out), .proto_err(r_perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic tick_clr();
    tick();
    s_data_ok = 1'b0;
    s_rdata   = '0;
  endtask

  // Drive one slave response this cycle and check it against the scoreboard head.
  task automatic resp(input logic [31:0] data, input bit use_rr);
    logic [1:0] exp;
    s_data_ok = 1'b1;
    s_rdata   = data;
    settle();
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 2'b00;
    if (use_rr) begin
      chk("rr_data_ok", 64'(r_m_data_ok), 64'(exp));
      chk("rr_rdata", 64'(r_m_rdata), 64'(data));
    end else begin
      chk("fix_data_ok", 64'(f_m_data_ok), 64'(exp));
      chk("fix_rdata", 64'(f_m_rdata), 64'(data));
    end
  endtask

  initial begin
    reset     = 1'b1;
    m_req     = '0;
    m_wr      = 2'b10;
    m_size    = {2'd2, 2'd0};
    m_addr    = {A1, A0};
    m_wdata   = {W1, W0};
    s_addr_ok = 1'b0;
    s_data_ok = 1'b0;
    s_rdata   = '0;
    tick();
    settle();
    chk("rst_s_req", 64'(f_s_req), 64'(0));
    chk("rst_out", 64'(f_out), 64'(0));
    chk("rst_perr", 64'(f_perr), 64'(0));
    chk("rst_addr_ok", 64'(f_m_addr_ok), 64'(0));
    chk("rst_s_addr", 64'(f_s_addr), 64'(0));
    tick();
    reset = 1'b0;
    tick();

    // single read on ch0, response two cycles after accept
    m_req = 2'b01; s_addr_ok = 1'b1;
    settle();
    chk("t1_addr_ok", 64'(f_m_addr_ok), 64'(2'b01));
    chk("t1_s_addr", 64'(f_s_addr), 64'(A0));
    chk("t1_s_wr", 64'(f_s_wr), 64'(0));
    chk("t1_out0", 64'(f_out), 64'(0));
    exp_q.push_back(2'b01);
    tick();
    m_req = 2'b00; s_addr_ok = 1'b0;
    settle();
    chk("t1_out1", 64'(f_out), 64'(1));
    chk("t1_idle_s_req", 64'(f_s_req), 64'(0));
    tick();
    resp(32'hDEAD_BEEF, 1'b0);
    tick_clr();
    settle();
    chk("t1_out_end", 64'(f_out), 64'(0));
    tick();

    // fixed priority starves ch1 until ch0 drops
    m_req = 2'b11; s_addr_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t2_grant0", 64'(f_m_addr_ok), 64'(2'b01));
      chk("t2_addr0", 64'(f_s_addr), 64'(A0));
      exp_q.push_back(2'b01);
      tick();
    end
    m_req = 2'b10;
    settle();
    chk("t2_grant1", 64'(f_m_addr_ok), 64'(2'b10));
    chk("t2_addr1", 64'(f_s_addr), 64'(A1));
    chk("t2_wr1", 64'(f_s_wr), 64'(1));
    chk("t2_size1", 64'(f_s_size), 64'(2));
    chk("t2_wdata1", 64'(f_s_wdata), 64'(W1));
    exp_q.push_back(2'b10);
    tick();
    m_req = 2'b00; s_addr_ok = 1'b0;
    settle();
    chk("t2_out4", 64'(f_out), 64'(4));
    tick();
    for (int i = 0; i < 4; i++) begin
      resp($urandom, 1'b0);
      tick_clr();
    end
    settle();
    chk("t2_out_end", 64'(f_out), 64'(0));

    reset = 1'b1;
    #1;
    reset = 1'b0;
    tick();

    // round-robin alternation, then full blocking
    m_req = 2'b11; s_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] g;
      g = (i % 2 == 0) ? 2'b01 : 2'b10;
      settle();
      chk("t3_rr_grant", 64'(r_m_addr_ok), 64'(g));
      chk("t3_rr_addr", 64'(r_s_addr), 64'((i % 2 == 0) ? A0 : A1));
      exp_q.push_back(g);
      tick();
    end
    settle();
    chk("t4_out_full", 64'(r_out), 64'(4));
    chk("t4_rr_sreq_full", 64'(r_s_req), 64'(0));
    chk("t4_fix_sreq_full", 64'(f_s_req), 64'(0));
    chk("t4_addr_ok_full", 64'(r_m_addr_ok), 64'(0));
    tick();
    resp($urandom, 1'b1);
    chk("t4_sreq_pop_cycle", 64'(r_s_req), 64'(0));
    tick_clr();
    settle();
    chk("t4_out3", 64'(r_out), 64'(3));
    chk("t4_sreq_reopen", 64'(r_s_req), 64'(1));
    chk("t4_rr_grant_after", 64'(r_m_addr_ok), 64'(2'b01));
    exp_q.push_back(2'b01);
    tick();
    m_req = 2'b00; s_addr_ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      resp($urandom, 1'b1);
      tick_clr();
    end
    settle();
    chk("t4_out_end", 64'(r_out), 64'(0));
    tick();

    // lock on ch1 holds against higher-priority ch0
    m_req = 2'b10; s_addr_ok = 1'b0;
    settle();
    chk("t5_addr_c1", 64'(f_s_addr), 64'(A1));
    chk("t5_no_ack", 64'(f_m_addr_ok), 64'(0));
    tick();
    m_req = 2'b11;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("t5_locked_addr", 64'(f_s_addr), 64'(A1));
      tick();
    end
    s_addr_ok = 1'b1;
    settle();
    chk("t5_accept_c1", 64'(f_m_addr_ok), 64'(2'b10));
    exp_q.push_back(2'b10);
    tick();
    settle();
    chk("t5_then_c0", 64'(f_m_addr_ok), 64'(2'b01));
    chk("t5_then_addr", 64'(f_s_addr), 64'(A0));
    exp_q.push_back(2'b01);
    tick();
    m_req = 2'b00; s_addr_ok = 1'b0;
    settle();
    chk("t5_perr_clean", 64'(f_perr), 64'(0));
    tick();
    for (int i = 0; i < 2; i++) begin
      resp($urandom, 1'b0);
      tick_clr();
    end

    // reset with two requests in flight, then a stray response
    m_req = 2'b01; s_addr_ok = 1'b1;
    tick();
    tick();
    m_req = 2'b00; s_addr_ok = 1'b0;
    settle();
    chk("t6_out2", 64'(f_out), 64'(2));
    reset = 1'b1;
    #1;
    chk("t6_rst_out", 64'(f_out), 64'(0));
    chk("t6_rst_rr_out", 64'(r_out), 64'(0));
    chk("t6_rst_sreq", 64'(f_s_req), 64'(0));
    #2;
    reset = 1'b0;
    tick();
    s_data_ok = 1'b1; s_rdata = 32'h0000_0123;
    settle();
    chk("t6_stray_data_ok", 64'(f_m_data_ok), 64'(0));
    chk("t6_stray_rdata", 64'(f_m_rdata), 64'(0));
    tick_clr();
    settle();
    chk("t6_perr", 64'(f_perr), 64'(1));
    chk("t6_out0", 64'(f_out), 64'(0));

    // locked channel withdraws: error flagged and arbitration moves on at once
    reset = 1'b1;
    #1;
    chk("t7_rst_perr", 64'(f_perr), 64'(0));
    reset = 1'b0;
    tick();
    m_req = 2'b10; s_addr_ok = 1'b0;
    settle();
    chk("t7_sreq_lock", 64'(f_s_req), 64'(1));
    tick();
    m_req = 2'b01; s_addr_ok = 1'b1;
    settle();
    chk("t7_rearb_grant", 64'(f_m_addr_ok), 64'(2'b01));
    chk("t7_rearb_addr", 64'(f_s_addr), 64'(A0));
    exp_q.push_back(2'b01);
    tick();
    m_req = 2'b00; s_addr_ok = 1'b0;
    settle();
    chk("t7_perr", 64'(f_perr), 64'(1));
    tick();
    resp($urandom, 1'b0);
    tick_clr();
    settle();
    chk("t7_out_end", 64'(f_out), 64'(0));
    chk("q_empty", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
